// File: rtl/ro_axil_pkg.sv
// Shared constants and FSM state types for the ring-oscillator AXI4-Lite register slave.
package ro_axil_pkg;

    localparam int ADDR_LSB = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ro_axil_regfile.sv
// NUM_REGS x 32 config storage; a write lands on the next edge together with a 1-cycle pulse.
// `RO_AXIL_WSTRB_EN enables per-byte strobe merging; otherwise whole words are written.
module ro_axil_regfile #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [31:0]               wr_data_i,
    input  logic [3:0]                wr_strb_i,
    output logic [NUM_REGS-1:0][31:0] regs_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]       pulse_q, pulse_d;

`ifndef RO_AXIL_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^wr_strb_i;
`endif

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                pulse_d[i] = 1'b1;
`ifdef RO_AXIL_WSTRB_EN
                for (int k = 0; k < 4; k++) begin
                    if (wr_strb_i[k]) begin
                        regs_d[i][8*k +: 8] = wr_data_i[8*k +: 8];
                    end
                end
`else
                regs_d[i] = wr_data_i;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/ro_axil_slave_regs.sv
// AXI4-Lite slave for RO config/status: B or R response one cycle after the last address/data beat,
// held until BREADY/RREADY with no new accepts meanwhile; `RO_AXIL_WSTRB_EN selects byte-strobe writes.
module ro_axil_slave_regs
    import ro_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   ro_count_i,
    output logic [NUM_REGS*32-1:0]          cfg_regs_o,
    output logic [NUM_REGS-1:0]             cfg_wr_o
);

    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W     = AW - ADDR_LSB;
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(NUM_REGS);

    // ---------------- write channel ----------------
    wr_state_t   wr_state_q, wr_state_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic          aw_hs, w_hs, aw_have, w_have, wr_commit, wr_hit;
    logic [AW-1:0] wr_addr;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    assign aw_hs   = S_AXI_AWVALID && awready_q;
    assign w_hs    = S_AXI_WVALID && wready_q;
    assign aw_have = aw_done_q || aw_hs;
    assign w_have  = w_done_q || w_hs;
    assign wr_commit = (wr_state_q == W_IDLE) && aw_have && w_have;

    // Bypass the holding registers when the beat arrives in the commit cycle itself.
    assign wr_addr = aw_done_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_done_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_done_q ? wstrb_q : S_AXI_WSTRB;
    assign wr_idx  = wr_addr[AW-1:ADDR_LSB];
    assign wr_hit  = wr_idx < RO_IDX;

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awaddr_d  = S_AXI_AWADDR;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    w_done_d = 1'b1;
                end
                awready_d = !aw_have;
                wready_d  = !w_have;
                if (wr_commit) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    logic [NUM_REGS-1:0][31:0] regs;

    ro_axil_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_regfile (
        .clk_i      (S_AXI_ACLK),
        .rst_ni     (S_AXI_ARESETN),
        .wr_en_i    (wr_commit && wr_hit),
        .wr_idx_i   (wr_idx[REG_IDX_W-1:0]),
        .wr_data_i  (wr_data),
        .wr_strb_i  (wr_strb),
        .regs_o     (regs),
        .wr_pulse_o (cfg_wr_o)
    );

    // ---------------- read channel ----------------
    rd_state_t   rd_state_q, rd_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ar_hs;
    logic [IDX_W-1:0] rd_idx;

    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign rd_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];

    // Data is captured from the pre-edge register state, so a coincident write is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                    if (rd_idx < RO_IDX) begin
                        rdata_d = regs[rd_idx[REG_IDX_W-1:0]];
                        rresp_d = RESP_OKAY;
                    end else if (rd_idx == RO_IDX) begin
                        rdata_d = ro_count_i;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0], wr_addr[ADDR_LSB-1:0]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign cfg_regs_o    = regs;

endmodule
